count_capture: RTL

//  Downstream consumer of the 16-bit loadable counter (`sequential`) output.
//  On a trigger strobe it snapshots the counter value and the delta since the previous snapshot.

---
 rtl/count_capture_pkg.sv | 17 +
 rtl/capture_fifo.sv | 47 ++++
 rtl/count_capture.sv | 88 ++++++++
 3 files changed

// File: rtl/count_capture_pkg.sv
// Shared types for the counter snapshot path: entry layout and history-tracker states.
package count_capture_pkg;
    localparam int CC_WIDTH = 16;

    typedef struct packed {
        logic [CC_WIDTH-1:0] count;
        logic [CC_WIDTH-1:0] delta;
        logic                first;
    } cap_entry_t;

    localparam int ENTRY_W = $bits(cap_entry_t);

    typedef enum logic {
        EMPTY_HIST = 1'b0,
        HAVE_HIST  = 1'b1
    } hist_state_t;
endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO of capture entries.
// The head slot is presented combinationally; pointers carry one extra wrap bit.
module capture_fifo
    import count_capture_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [ENTRY_W-1:0]     din,
    output logic [ENTRY_W-1:0]     dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: empty/level gate every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
endmodule

// File: rtl/count_capture.sv
// Snapshots the upstream counter on trig, tags each entry with the delta since the
// previous stored capture, and buffers it for a valid/ready consumer.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int WIDTH = CC_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       count,
    input  logic                   trig,
    input  logic                   clear,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_count,
    output logic [WIDTH-1:0]       rd_delta,
    output logic                   rd_first,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   hist_state
);
    // Handshake: an entry moves on a rising clk where rd_valid && rd_ready are both high;
    // rd_valid depends only on stored state, never on rd_ready.
    hist_state_t      state;
    logic [WIDTH-1:0] last_cap;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             slot;
    cap_entry_t       wr_entry;
    cap_entry_t       head;

    assign rd_valid = !empty;
    assign pop      = rd_valid && rd_ready && !clear;
    assign slot     = !full || pop;
    assign push     = trig && slot && !clear;

    always_comb begin
        wr_entry       = '0;
        wr_entry.count = count;
        if (state == HAVE_HIST) begin
            wr_entry.delta = count - last_cap;
            wr_entry.first = 1'b0;
        end else begin
            wr_entry.delta = '0;
            wr_entry.first = 1'b1;
        end
    end

    capture_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (push),
        .pop   (pop),
        .din   (wr_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // A dropped capture leaves last_cap alone so the next delta spans the gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY_HIST;
            last_cap <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            state    <= EMPTY_HIST;
            last_cap <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                last_cap <= count;
                state    <= HAVE_HIST;
            end
            if (trig && !slot) overflow <= 1'b1;
        end
    end

    assign rd_count   = rd_valid ? head.count : '0;
    assign rd_delta   = rd_valid ? head.delta : '0;
    assign rd_first   = rd_valid ? head.first : 1'b0;
    assign hist_state = state;
endmodule
